// File: rtl/sram_arbiter.sv
// sram_arbiter
// Shares one asynchronous 16-bit SRAM between a read-only video fetcher and a
// CPU data port. Video reads take two cycles from grant to ack; CPU writes run
// a three-cycle setup / pulse / hold sequence. Video normally wins conflicts,
// but after VID_MAX back-to-back video grants with the CPU waiting, the CPU
// is served next. Every output comes straight from a flop.
//
// Ports
//   clk_vga, rst_n            clock and asynchronous active-low reset
//   vid_req/vid_adr           video read request and word address
//   vid_ack/vid_dat           one-cycle completion pulse and read data
//   dm_req/dm_we/dm_adr/dm_wdat  CPU request, direction, word address, write data
//   dm_ack/dm_rdat            one-cycle completion pulse and read data
//   sram_a/sram_dout/sram_din SRAM address and pad data
//   sram_drive                pad output enable
//   sram_ce_n..sram_ub_n      active-low SRAM strobes
module sram_arbiter #(
  parameter logic [17:0] DM_BASE = 18'h20000,
  parameter int unsigned VID_MAX = 4
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        vid_req,
  input  logic [17:0] vid_adr,
  output logic        vid_ack,
  output logic [15:0] vid_dat,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_adr,
  input  logic [15:0] dm_wdat,
  output logic [15:0] dm_rdat,
  output logic        dm_ack,
  output logic [17:0] sram_a,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_drive,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam int unsigned CW = $clog2(VID_MAX + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(VID_MAX);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] run_q, run_d;
  logic          rd_vid_q, rd_vid_d;
  logic [17:0]   sram_a_q, sram_a_d;
  logic [15:0]   sram_dout_q, sram_dout_d;
  logic [15:0]   vid_dat_q, vid_dat_d;
  logic [15:0]   dm_rdat_q, dm_rdat_d;
  logic          vid_ack_q, vid_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          byte_n_q, byte_n_d;
  logic          drive_q, drive_d;

  logic          vid_elig, dm_elig;
  logic          grant_vid, grant_dm;
  logic [17:0]   dm_full_adr;

  // CPU addresses live in a window starting at DM_BASE; the sum wraps at 2^18.
  assign dm_full_adr = DM_BASE + {2'b00, dm_adr};

  // State and all output flops. Reset drops the pad drive and raises every
  // strobe at once, so an interrupted write cannot leave the SRAM driven.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      run_q       <= '0;
      rd_vid_q    <= 1'b0;
      sram_a_q    <= '0;
      sram_dout_q <= '0;
      vid_dat_q   <= '0;
      dm_rdat_q   <= '0;
      vid_ack_q   <= 1'b0;
      dm_ack_q    <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      byte_n_q    <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      rd_vid_q    <= rd_vid_d;
      sram_a_q    <= sram_a_d;
      sram_dout_q <= sram_dout_d;
      vid_dat_q   <= vid_dat_d;
      dm_rdat_q   <= dm_rdat_d;
      vid_ack_q   <= vid_ack_d;
      dm_ack_q    <= dm_ack_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      byte_n_q    <= byte_n_d;
      drive_q     <= drive_d;
    end
  end

  // Arbitration and next state. A requester whose ack is showing this cycle is
  // masked, so a request held through its own ack is not granted twice. The
  // run counter only climbs while the CPU is actually waiting.
  always_comb begin
    vid_elig  = vid_req && !vid_ack_q;
    dm_elig   = dm_req && !dm_ack_q;
    grant_vid = 1'b0;
    grant_dm  = 1'b0;
    state_d   = state_q;
    run_d     = run_q;
    case (state_q)
      IDLE: begin
        if (vid_elig && !(dm_elig && (run_q == RUN_MAX))) begin
          grant_vid = 1'b1;
        end else if (dm_elig) begin
          grant_dm = 1'b1;
        end
        if (grant_vid) begin
          state_d = RD;
          if (dm_req) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + CW'(1);
          end else begin
            run_d = '0;
          end
        end else if (grant_dm) begin
          state_d = dm_we ? WR_SETUP : RD;
          run_d   = '0;
        end
      end
      RD:       state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output values to be registered at the next edge. Strobes default to idle,
  // so each state only lists what it asserts on the way into its successor.
  // Address and write data are kept after a transaction ends.
  always_comb begin
    sram_a_d    = sram_a_q;
    sram_dout_d = sram_dout_q;
    vid_dat_d   = vid_dat_q;
    dm_rdat_d   = dm_rdat_q;
    rd_vid_d    = rd_vid_q;
    vid_ack_d   = 1'b0;
    dm_ack_d    = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    byte_n_d    = 1'b1;
    drive_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vid) begin
          sram_a_d = vid_adr;
          rd_vid_d = 1'b1;
          ce_n_d   = 1'b0;
          oe_n_d   = 1'b0;
          byte_n_d = 1'b0;
        end else if (grant_dm) begin
          sram_a_d = dm_full_adr;
          rd_vid_d = 1'b0;
          ce_n_d   = 1'b0;
          byte_n_d = 1'b0;
          if (dm_we) begin
            drive_d     = 1'b1;
            sram_dout_d = dm_wdat;
          end else begin
            oe_n_d = 1'b0;
          end
        end
      end
      RD: begin
        if (rd_vid_q) begin
          vid_dat_d = sram_din;
          vid_ack_d = 1'b1;
        end else begin
          dm_rdat_d = sram_din;
          dm_ack_d  = 1'b1;
        end
      end
      WR_SETUP: begin
        ce_n_d   = 1'b0;
        byte_n_d = 1'b0;
        drive_d  = 1'b1;
        we_n_d   = 1'b0;
      end
      WR_PULSE: begin
        ce_n_d   = 1'b0;
        byte_n_d = 1'b0;
        drive_d  = 1'b1;
      end
      WR_HOLD: begin
        dm_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign sram_a     = sram_a_q;
  assign sram_dout  = sram_dout_q;
  assign vid_dat    = vid_dat_q;
  assign dm_rdat    = dm_rdat_q;
  assign vid_ack    = vid_ack_q;
  assign dm_ack     = dm_ack_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = byte_n_q;
  assign sram_ub_n  = byte_n_q;
  assign sram_drive = drive_q;

endmodule
